piso_serializer: RTL and testbench

Parallel-in/serial-out transmitter that sits directly upstream of the team's SIPO shift register and drives its `SI` input. It accepts an `n`-bit word through a valid/ready handshake and emits it one bit per `clk` with a qualifying strobe. An optional idle gap follows each word. With the default LSB-first order, a right-shifting `n`-bit SIPO clocked alongside holds the original word after exactly `n` qualified bits.

---
 rtl/piso_serializer.sv | 143 ++++++++++++++
 tb/tb_piso_serializer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// -----------------------------------------------------------------------------
// piso_serializer
//
// Parallel-in / serial-out transmitter. A word of n bits is accepted through a
// valid/ready handshake and sent one bit per clock on SO, qualified by
// SO_valid. It is meant to drive the SI input of a SIPO shift register that is
// clocked alongside. An optional idle gap of GAP cycles follows every word.
//
// Parameters
//   n          word width (n >= 2)
//   GAP        idle cycles after each word (GAP >= 0)
//   MSB_FIRST  0: D[0] is sent first, 1: D[n-1] is sent first
//
// Ports
//   clk         single clock, rising edge
//   reset_n     asynchronous, active-low reset
//   D           parallel word, sampled only on an accepted handshake
//   load_valid  upstream presents a word on D
//   load_ready  a word can be accepted this cycle (combinational from state)
//   SO          serial data, 0 whenever SO_valid is 0 (registered)
//   SO_valid    SO carries a word bit (registered)
//   busy        state is SHIFT or GAP
//   done        one-cycle pulse alongside the last bit of a word (registered)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module piso_serializer #(
  parameter int n         = 5,
  parameter int GAP       = 0,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [n-1:0] D,
  input  logic         load_valid,
  output logic         load_ready,
  output logic         SO,
  output logic         SO_valid,
  output logic         busy,
  output logic         done
);

  localparam int CW = $clog2(n);
  // The gap counter is kept one bit wide when GAP=0; it is never advanced then.
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(n - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t        state_reg;
  logic [n-1:0]  data_reg;
  logic [CW-1:0] bit_cnt_reg;
  logic [GW-1:0] gap_cnt_reg;

  logic          last_bit;
  logic          accept;
  logic          out_bit;
  logic [n-1:0]  data_shifted;

  // In SHIFT each cycle hands one bit to the output register; the cycle with
  // bit_cnt_reg at n-1 is the one that hands over the last bit.
  assign last_bit   = (state_reg == S_SHIFT) && (bit_cnt_reg == BIT_LAST);

  // With no gap, a new word may be taken in the last-bit cycle so that its
  // first bit follows the previous word's last bit without a hole.
  assign load_ready = (state_reg == S_IDLE) || (last_bit && (GAP == 0));
  assign accept     = load_valid && load_ready;
  assign busy       = (state_reg != S_IDLE);

  assign out_bit      = MSB_FIRST ? data_reg[n-1] : data_reg[0];
  assign data_shifted = MSB_FIRST ? {data_reg[n-2:0], 1'b0}
                                  : {1'b0, data_reg[n-1:1]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= S_IDLE;
      data_reg    <= '0;
      bit_cnt_reg <= '0;
      gap_cnt_reg <= '0;
      SO          <= 1'b0;
      SO_valid    <= 1'b0;
      done        <= 1'b0;
    end else begin
      // Outputs default to idle; only SHIFT drives a qualified bit.
      SO       <= 1'b0;
      SO_valid <= 1'b0;
      done     <= 1'b0;

      case (state_reg)
        S_IDLE: begin
          if (accept) begin
            data_reg    <= D;
            bit_cnt_reg <= '0;
            state_reg   <= S_SHIFT;
          end
        end

        S_SHIFT: begin
          SO       <= out_bit;
          SO_valid <= 1'b1;
          done     <= (bit_cnt_reg == BIT_LAST);
          data_reg <= data_shifted;

          if (bit_cnt_reg != BIT_LAST) begin
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
          end else if (GAP > 0) begin
            // GAP is entered while the last bit sits on SO, so the counter
            // runs 0..GAP: one cycle for the last bit, then GAP idle cycles.
            bit_cnt_reg <= '0;
            gap_cnt_reg <= '0;
            state_reg   <= S_GAP;
          end else if (accept) begin
            data_reg    <= D;
            bit_cnt_reg <= '0;
            state_reg   <= S_SHIFT;
          end else begin
            bit_cnt_reg <= '0;
            state_reg   <= S_IDLE;
          end
        end

        S_GAP: begin
          if (gap_cnt_reg == GAP_LAST) begin
            gap_cnt_reg <= '0;
            state_reg   <= S_IDLE;
          end else begin
            gap_cnt_reg <= gap_cnt_reg + 1'b1;
          end
        end

        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// -----------------------------------------------------------------------------
// tb_piso_serializer
//
// Three instances of piso_serializer (n=5): LSB-first with no gap, LSB-first
// with GAP=2, and MSB-first with no gap. Expected bits are queued when a word
// is accepted and popped by a negedge monitor as SO_valid bits appear.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_piso_serializer;

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [4:0] d   [3];
  logic       lv  [3];
  logic       lr  [3];
  logic       so  [3];
  logic       sov [3];
  logic       bsy [3];
  logic       dn  [3];

  always #5 clk = ~clk;

  piso_serializer #(.n(5), .GAP(0), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset_n(reset_n), .D(d[0]), .load_valid(lv[0]),
    .load_ready(lr[0]), .SO(so[0]), .SO_valid(sov[0]), .busy(bsy[0]), .done(dn[0])
  );

  piso_serializer #(.n(5), .GAP(2), .MSB_FIRST(1'b0)) u_gap (
    .clk(clk), .reset_n(reset_n), .D(d[1]), .load_valid(lv[1]),
    .load_ready(lr[1]), .SO(so[1]), .SO_valid(sov[1]), .busy(bsy[1]), .done(dn[1])
  );

  piso_serializer #(.n(5), .GAP(0), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset_n(reset_n), .D(d[2]), .load_valid(lv[2]),
    .load_ready(lr[2]), .SO(so[2]), .SO_valid(sov[2]), .busy(bsy[2]), .done(dn[2])
  );

  int total = 0;
  int bad   = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int   nbits    [3];
  int   done_cnt [3];
  int   vrun     [3];
  int   vmax     [3];
  int   rb_cnt   [3];
  time  accept_t [3];

  logic [4:0] sipo;       // downstream right-shifting SIPO fed by u_lsb
  logic [4:0] obs2;       // u_msb stream, first bit ends up in the MSB
  int         gap_runs[$];
  int         g_cnt;
  bit         g_on;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic int qsize(input int idx);
    case (idx)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic exp_t qpop(input int idx);
    case (idx)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  task automatic qpush(input int idx, input exp_t e);
    case (idx)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic mon_step(input int idx, input logic so_v, input logic sov_v,
                          input logic dn_v, input logic lr_v, input logic bsy_v);
    exp_t e;
    if (sov_v) begin
      if (qsize(idx) == 0) begin
        check_eq($sformatf("extra_bit_dut%0d", idx), 32'd1, 32'd0);
      end else begin
        e = qpop(idx);
        check_eq($sformatf("so_dut%0d", idx), {31'd0, so_v}, {31'd0, e.b});
        check_eq($sformatf("done_dut%0d", idx), {31'd0, dn_v}, {31'd0, e.last});
      end
      nbits[idx]++;
      vrun[idx]++;
      if (vrun[idx] > vmax[idx]) vmax[idx] = vrun[idx];
      if (idx == 0) sipo = {so_v, sipo[4:1]};
      if (idx == 2) obs2 = {obs2[3:0], so_v};
    end else begin
      check_eq($sformatf("so_idle_dut%0d", idx), {31'd0, so_v}, 32'd0);
      check_eq($sformatf("done_idle_dut%0d", idx), {31'd0, dn_v}, 32'd0);
      vrun[idx] = 0;
    end
    if (!bsy_v) check_eq($sformatf("ready_idle_dut%0d", idx), {31'd0, lr_v}, 32'd1);
    if (lr_v && bsy_v) rb_cnt[idx]++;
    if (dn_v) done_cnt[idx]++;
    if (idx == 1) begin
      if (g_on) begin
        if (!sov_v && bsy_v && !lr_v) begin
          g_cnt++;
        end else begin
          gap_runs.push_back(g_cnt);
          g_on = 1'b0;
        end
      end
      if (dn_v) begin
        g_on  = 1'b1;
        g_cnt = 0;
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      mon_step(0, so[0], sov[0], dn[0], lr[0], bsy[0]);
      mon_step(1, so[1], sov[1], dn[1], lr[1], bsy[1]);
      mon_step(2, so[2], sov[2], dn[2], lr[2], bsy[2]);
    end
  end

  // Presents a word and waits (bounded) for the handshake; queues the expected
  // bit stream on acceptance. With hold set, load_valid stays high on return.
  task automatic send_word(input int idx, input logic [4:0] data, input bit hold);
    bit   got = 1'b0;
    exp_t e;
    d[idx]  = data;
    lv[idx] = 1'b1;
    for (int w = 0; w < 60; w++) begin
      @(negedge clk);
      if (lr[idx]) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      check_eq($sformatf("accept_timeout_dut%0d", idx), 32'd0, 32'd1);
      lv[idx] = 1'b0;
      return;
    end
    @(posedge clk);
    accept_t[idx] = $time;
    for (int i = 0; i < 5; i++) begin
      e.b    = (idx == 2) ? data[4-i] : data[i];
      e.last = (i == 4);
      qpush(idx, e);
    end
    $display("xfer dut=%0d D=%b t=%0t", idx, data, $time);
    #1;
    if (!hold) lv[idx] = 1'b0;
  endtask

  task automatic drain(input int idx);
    bit ok = 1'b0;
    for (int w = 0; w < 60; w++) begin
      @(negedge clk);
      if (qsize(idx) == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_eq($sformatf("drain_timeout_dut%0d", idx), 32'd0, 32'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("%s_so%0d", tag, i),    {31'd0, so[i]},  32'd0);
      check_eq($sformatf("%s_sov%0d", tag, i),   {31'd0, sov[i]}, 32'd0);
      check_eq($sformatf("%s_done%0d", tag, i),  {31'd0, dn[i]},  32'd0);
      check_eq($sformatf("%s_busy%0d", tag, i),  {31'd0, bsy[i]}, 32'd0);
      check_eq($sformatf("%s_ready%0d", tag, i), {31'd0, lr[i]},  32'd1);
    end
  endtask

  initial begin
    int  base;
    int  dbase;
    time t1;
    time t2;

    reset_n = 1'b1;
    sipo    = '0;
    obs2    = '0;
    g_cnt   = 0;
    g_on    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      d[i] = '0; lv[i] = 1'b0;
      nbits[i] = 0; done_cnt[i] = 0; vrun[i] = 0; vmax[i] = 0; rb_cnt[i] = 0;
      accept_t[i] = 0;
    end

    // Reset asserted mid-cycle: outputs must settle before any clock edge.
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1 check_reset_outputs("rst_async");
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    @(posedge clk);
    #1 check_reset_outputs("rst_release");

    // LSB-first word; monitor checks 0,1,1,0,1 and done on the 5th bit only.
    send_word(0, 5'b10110, 1'b0);
    drain(0);
    check_eq("sipo_q", {27'd0, sipo}, 32'b10110);
    check_eq("w1_bits", nbits[0], 32'd5);
    check_eq("w1_done", done_cnt[0], 32'd1);

    // Back-to-back, GAP=0: one unbroken run of 10 valid bits.
    vmax[0]   = 0;
    rb_cnt[0] = 0;
    send_word(0, 5'b00011, 1'b1);
    send_word(0, 5'b11100, 1'b0);
    drain(0);
    check_eq("b2b_run", vmax[0], 32'd10);
    check_eq("b2b_ready_busy", rb_cnt[0], 32'd2);
    check_eq("b2b_bits", nbits[0], 32'd15);

    // Load attempt while not ready must be ignored.
    base = nbits[0];
    send_word(0, 5'b01010, 1'b0);
    repeat (2) @(posedge clk);
    #1 d[0] = 5'b11111; lv[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1 lv[0] = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check_eq("ign_bits", nbits[0] - base, 32'd5);
    check_eq("ign_queue", q0.size(), 32'd0);

    // GAP=2 instance with two words offered back to back.
    send_word(1, 5'b10101, 1'b1);
    t1 = accept_t[1];
    send_word(1, 5'b01101, 1'b0);
    t2 = accept_t[1];
    drain(1);
    repeat (5) @(posedge clk);
    #1;
    check_eq("gap_period_ok", {31'd0, ((t2 - t1) / 10) >= 8}, 32'd1);
    check_eq("gap_runs", gap_runs.size(), 32'd2);
    foreach (gap_runs[i]) check_eq($sformatf("gap_len%0d", i), gap_runs[i], 32'd2);

    // Reset during the third bit of 5'b11111.
    dbase = done_cnt[0];
    send_word(0, 5'b11111, 1'b0);
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b0;
    q0.delete();
    #1 check_reset_outputs("rst_mid");
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_no_done", done_cnt[0] - dbase, 32'd0);
    base = nbits[0];
    send_word(0, 5'b00001, 1'b0);
    drain(0);
    check_eq("post_rst_bits", nbits[0] - base, 32'd5);
    check_eq("post_rst_sipo", {27'd0, sipo}, 32'b00001);
    check_eq("post_rst_done", done_cnt[0] - dbase, 32'd1);

    // MSB-first: stream 1,0,1,1,0.
    send_word(2, 5'b10110, 1'b0);
    drain(2);
    check_eq("msb_stream", {27'd0, obs2}, 32'b10110);
    check_eq("msb_done", done_cnt[2], 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
